// File: rtl/booth_mult16.sv
// ============================================================================
// Module      : booth_mult16
// Description : Sequential radix-2 Booth multiplier for signed operands.
//               Both operands arrive one after the other on a shared bus.
//               The block runs one Booth iteration per clock and presents the
//               exact 2*WIDTH-bit signed product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // The counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_M = 3'd1;
  localparam logic [2:0] S_LOAD_Q = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next;

  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  // Accumulator carries one extra sign bit so that M = most-negative is exact.
  logic [WIDTH:0]   r_a;
  logic             r_qm1;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_msext;
  logic [WIDTH:0]   w_t;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; start is only looked at in IDLE and DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD_M;
      S_LOAD_M: w_next = S_LOAD_Q;
      S_LOAD_Q: w_next = S_RUN;
      S_RUN:    if (r_cnt == C_CNT_ONE) w_next = S_DONE;
      S_DONE:   if (!start) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output decode: result valid only while parked in DONE.
  always_comb begin
    done = 1'b0;
    if (r_state == S_DONE) done = 1'b1;
  end

  // Booth add/subtract selection on {Q[0], qm1}.
  always_comb begin
    w_msext = {r_m[WIDTH-1], r_m};
    w_t     = r_a;
    case ({r_q[0], r_qm1})
      2'b01:   w_t = r_a + w_msext;
      2'b10:   w_t = r_a - w_msext;
      default: w_t = r_a;
    endcase
  end

  // Datapath: operand capture and one arithmetic right shift per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m   <= '0;
      r_q   <= '0;
      r_a   <= '0;
      r_qm1 <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_LOAD_M: r_m <= data_in;
        S_LOAD_Q: begin
          r_q   <= data_in;
          r_a   <= '0;
          r_qm1 <= 1'b0;
          r_cnt <= C_CNT_INIT;
        end
        S_RUN: begin
          r_a   <= {w_t[WIDTH], w_t[WIDTH:1]};
          r_q   <= {w_t[0], r_q[WIDTH-1:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt - C_CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign product = {r_a[WIDTH-1:0], r_q};

endmodule

`default_nettype wire

// File: tb/tb_booth_mult16.sv
// ============================================================================
// Module      : tb_booth_mult16
// Description : Self-checking bench for booth_mult16. Directed cases use known
//               products; random operand pairs use plain signed arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mult16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data_in;
  logic        done;
  logic [31:0] product;

  int n_vec;
  int n_err;

  booth_mult16 #(.WIDTH(16)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed product from ordinary integer arithmetic.
  function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q);
    int mi;
    int qi;
    mi = int'($signed(m));
    qi = int'($signed(q));
    return 32'(mi * qi);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction. Entered in IDLE with start low, just after an edge.
  // Leaves the DUT back in IDLE with start low.
  task automatic run_mult(input logic [15:0] m, input logic [15:0] q,
                          input logic [31:0] exp, input string tag);
    logic [31:0] first;
    start   = 1'b1;
    data_in = 16'($urandom);           // ignored in IDLE
    tick();                            // edge k: start sampled
    chk({tag, " done@LOAD_M"}, {31'd0, done}, 32'd0);
    data_in = m;
    tick();                            // edge k+1: M captured
    data_in = q;
    tick();                            // edge k+2: Q captured
    data_in = 16'($urandom);
    // Edges k+3..k+17: busy; start wiggles must not matter here.
    for (int i = 0; i < 15; i++) begin
      start = 1'($urandom);
      tick();
      if (i == 0 || i == 14)
        chk({tag, " done@RUN"}, {31'd0, done}, 32'd0);
    end
    start = 1'b1;
    tick();                            // edge k+18: DONE
    chk({tag, " done@k+18"}, {31'd0, done}, 32'd1);
    chk({tag, " product"}, product, exp);
    first = product;
    data_in = 16'($urandom);
    tick();
    chk({tag, " done hold"}, {31'd0, done}, 32'd1);
    chk({tag, " product hold"}, product, first);
    start = 1'b0;
    tick();
    chk({tag, " done@IDLE"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [15:0] m;
    logic [15:0] q;
    n_vec   = 0;
    n_err   = 0;
    start   = 1'b0;
    data_in = 16'h0;
    rst_n   = 1'b0;
    #2;
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle done", {31'd0, done}, 32'd0);

    // Directed cases with hand-computed products.
    run_mult(16'd35, 16'd30, 32'h0000041A, "basic");
    run_mult(16'hFFF9, 16'd5, 32'hFFFFFFDD, "mixed");
    run_mult(16'h8000, 16'h8000, 32'h40000000, "minxmin");
    run_mult(16'h7FFF, 16'h8000, 32'hC0008000, "maxxmin");
    run_mult(16'h0000, 16'h1234, 32'h00000000, "zero");

    // Reset in the middle of the iterations.
    start   = 1'b1;
    data_in = 16'h5A5A;
    tick();
    data_in = 16'h1357;
    tick();
    data_in = 16'hBEEF;
    tick();
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrun rst done", {31'd0, done}, 32'd0);
    chk("midrun rst product", product, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_mult(16'd3, 16'd4, 32'd12, "after reset");

    // Back-to-back runs separated by one low cycle of start.
    run_mult(16'd100, 16'hFF9C, 32'hFFFFD8F0, "restart");

    // Random operand pairs, with extreme values mixed in.
    for (int n = 0; n < 40; n++) begin
      m = 16'($urandom);
      q = 16'($urandom);
      if (n % 8 == 1) m = 16'h8000;
      if (n % 8 == 2) q = 16'h8000;
      if (n % 8 == 3) q = 16'hFFFF;
      if (n % 8 == 4) m = 16'h7FFF;
      run_mult(m, q, ref_mul(m, q), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/booth_mult16.md
BOOTH_MULT16 -- requirements
Module: booth_mult16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; all widths below are stated for WIDTH=16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit; it is a level request to begin a multiplication, sampled in IDLE.
REQ-005 The block SHALL have port data_in, input, 16 bits; it is a shared operand bus, carrying the multiplicand in the LOAD_M cycle and the multiplier in the LOAD_Q cycle.
REQ-006 The block SHALL have port done, output, 1 bit; it is high while the result is valid.
REQ-007 The block SHALL have port product, output, 32 bits; it is the signed product, equal to {A[15:0],Q}.

Function
REQ-008 Operands and product SHALL be two's-complement signed.
REQ-009 Internal registers SHALL be M (16 b), Q (16 b), A (17 b, sign-extended accumulator so that M=-32768 is exact), qm1 (1 b) and cnt (5 b).
REQ-010 The controller SHALL implement the states IDLE, LOAD_M, LOAD_Q, RUN and DONE.
REQ-011 IDLE SHALL go to LOAD_M at the first rising edge with start=1; otherwise it stays in IDLE.
REQ-012 LOAD_M SHALL load M<=data_in and go to LOAD_Q.
REQ-013 LOAD_Q SHALL load Q<=data_in, clear A and qm1, set cnt<=16, and go to RUN.
REQ-014 RUN SHALL perform one Booth iteration per clock, based on {Q[0],qm1}.
REQ-015 In a RUN iteration, {Q[0],qm1}=01 SHALL give T=A+sext(M), 10 SHALL give T=A-sext(M), and 00 or 11 SHALL give T=A.
REQ-016 Each RUN iteration SHALL arithmetic-shift {T,Q,qm1} right by one (T[16] replicated) and decrement cnt.
REQ-017 RUN SHALL go to DONE on the edge where cnt goes from 1 to 0, after exactly 16 iterations.
REQ-018 done SHALL be 1 only in DONE, and product SHALL be stable throughout DONE.
REQ-019 DONE SHALL return to IDLE when start=0; while start stays 1, DONE SHALL hold.
REQ-020 A new multiplication therefore requires start to go low and then high again.
REQ-021 Latency SHALL be as follows, with start first sampled at edge k: M loaded at k+1, Q at k+2, iterations at k+3..k+18, and done=1 after edge k+18 (18 cycles).
REQ-022 product SHALL continuously reflect {A[15:0],Q}; it is only meaningful while done=1.
REQ-023 data_in SHALL be ignored in every state other than LOAD_M and LOAD_Q.
REQ-024 A start pulse during LOAD_M, LOAD_Q or RUN SHALL have no effect.
REQ-025 Overflow SHALL be impossible: A is 17 bits wide, and the full 32-bit signed result is exact for all operand pairs, including -32768 x -32768.

Reset
REQ-026 rst_n=0 SHALL immediately force the state to IDLE and clear done, A, Q, M, qm1 and cnt, so that product=0.
REQ-027 A reset asserted during any state, including mid-RUN, SHALL abort the operation with no residual effect.
REQ-028 After rst_n is released, the block SHALL wait in IDLE for start.

Verification
REQ-029 Basic multiply: hold start=1; data_in=35 in the LOAD_M cycle, then 30 in the LOAD_Q cycle -> done rises 18 cycles after start is sampled, product=1050 (0x0000041A), and done stays high while start=1.
REQ-030 Mixed signs: M=-7 (0xFFF9), Q=5 -> product=0xFFFFFFDD (-35).
REQ-031 Extremes: M=-32768, Q=-32768 -> product=0x40000000; separately, M=32767, Q=-32768 -> product=0xC0008000.
REQ-032 Zero: M=0, Q=0x1234 -> product=0, with done timing identical to REQ-029.
REQ-033 Reset mid-RUN: assert rst_n=0 at iteration 8 -> done=0 and product=0 immediately; after release with start=1, a fresh 3x4 run gives product=12.
REQ-034 Restart: after a completed run, drop start for one cycle and raise it again with new operands 100 and -100 -> the second result is 0xFFFFD8F0 (-10000), and done is low during the reload and run.
